// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port system memory (RAM/ROM/I/O window) between two bus
// masters: master 0 (CPU6 core) and master 1 (DMA / console loader).
// Ownership is granted round-robin. While the other master is waiting, an
// owner may make at most MAX_HOLD consecutive accesses. An owner with no
// competition keeps the port for as long as it keeps requesting.
//
// The winner's address, write enable and write data are steered onto the
// memory port. Read data is captured at the end of the access cycle and
// returned together with a one-cycle acknowledge.
//
// Parameters
//   ADDR_WIDTH  address width of the masters and the memory port
//   DATA_WIDTH  data width
//   MAX_HOLD    max consecutive accesses by one owner while the other master
//               requests (1..255)
//
// Ports
//   i_clk                 system clock, rising-edge active
//   i_rst_n               asynchronous active-low reset
//   i_mX_req              master X requests an access this cycle
//   i_mX_we               master X: 1 = write, 0 = read
//   i_mX_addr             master X access address
//   i_mX_wdata            master X write data
//   o_mX_gnt              master X currently owns the memory port
//   o_mX_ack              one-cycle pulse: master X's access in the
//                         previous cycle completed
//   o_mX_rdata            registered read data, valid while o_mX_ack = 1
//   o_mem_addr            memory address
//   o_mem_we              memory write enable
//   o_mem_wdata           memory write data
//   i_mem_rdata           combinational read data from memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_gnt,
  output logic                  o_m0_ack,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,

  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_ack,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,

  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  // Last hold count value an owner may reach; the access made at this count
  // is the final one before a forced handover.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last;      // most recent owner (0 or 1)
  logic [7:0]            r_hold_cnt;  // owner accesses since state entry
  logic                  r_m0_ack;
  logic                  r_m1_ack;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;

  logic w_acc0;       // master 0 access in this cycle
  logic w_acc1;       // master 1 access in this cycle
  logic w_hold_last;  // owner has used its final contested slot

  assign w_acc0      = (r_state == OWN0) && i_m0_req;
  assign w_acc1      = (r_state == OWN1) && i_m1_req;
  assign w_hold_last = (r_hold_cnt == HOLD_LAST);

  // Grants decode straight from the registered state, so the two grants can
  // never be high together.
  assign o_m0_gnt   = (r_state == OWN0);
  assign o_m1_gnt   = (r_state == OWN1);
  assign o_m0_ack   = r_m0_ack;
  assign o_m1_ack   = r_m1_ack;
  assign o_m0_rdata = r_m0_rdata;
  assign o_m1_rdata = r_m1_rdata;

  // Memory port steering. This is combinational from the state register, so
  // an asynchronous reset drops the write enable in the same cycle and the
  // interrupted write never reaches memory.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    if (w_acc0) begin
      o_mem_addr  = i_m0_addr;
      o_mem_we    = i_m0_we;
      o_mem_wdata = i_m0_wdata;
    end else if (w_acc1) begin
      o_mem_addr  = i_m1_addr;
      o_mem_we    = i_m1_we;
      o_mem_wdata = i_m1_wdata;
    end
  end

  // Arbitration FSM together with the acknowledge / read-data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      // Completion of this cycle's access. Writes acknowledge too and
      // return whatever the memory presents at that address.
      r_m0_ack <= w_acc0;
      r_m1_ack <= w_acc1;
      if (w_acc0) begin
        r_m0_rdata <= i_mem_rdata;
      end
      if (w_acc1) begin
        r_m1_rdata <= i_mem_rdata;
      end

      case (r_state)
        IDLE: begin
          r_hold_cnt <= '0;
          // On a tie the master that was not the last owner wins.
          if (i_m0_req && (!i_m1_req || r_last)) begin
            r_state <= OWN0;
            r_last  <= 1'b0;
          end else if (i_m1_req) begin
            r_state <= OWN1;
            r_last  <= 1'b1;
          end
        end

        OWN0: begin
          if (!i_m0_req) begin
            // Owner released: the dead cycle is this one, with no access.
            r_hold_cnt <= '0;
            if (i_m1_req) begin
              r_state <= OWN1;
              r_last  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_hold_last && i_m1_req) begin
            // Final contested access completes now; m1 takes over next
            // cycle with no idle gap.
            r_state    <= OWN1;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
          end else if (!w_hold_last) begin
            // Saturates at HOLD_LAST so an uncontested owner never loses
            // the port, yet a newly arriving competitor is served after
            // this owner's next access.
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        OWN1: begin
          if (!i_m1_req) begin
            r_hold_cnt <= '0;
            if (i_m0_req) begin
              r_state <= OWN0;
              r_last  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_hold_last && i_m0_req) begin
            r_state    <= OWN0;
            r_last     <= 1'b0;
            r_hold_cnt <= '0;
          end else if (!w_hold_last) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
